// File: rtl/box_plotter_pkg.sv
// rtl/box_plotter_pkg.sv - shared types and screen constants for the tile drawing path
package box_plotter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tiles are one pixel smaller than the grid pitch so neighbours keep a 1-pixel gap.
    localparam int BOX_W_DEF = 10;
    localparam int BOX_H_DEF = 7;
    localparam int PITCH_X   = 11;
    localparam int PITCH_Y   = 8;
    localparam int ORIGIN_X  = 28;
    localparam int ORIGIN_Y  = 30;

    localparam logic [2:0] COLOUR_RED   = 3'b100;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/box_plotter_raster_counter.sv
// rtl/box_plotter_raster_counter.sv - row-major dx/dy scan counter with last-column/last-pixel flags
module box_plotter_raster_counter #(
    parameter int BOX_W = 10,
    parameter int BOX_H = 7,
    localparam int XW = $clog2(BOX_W),
    localparam int YW = $clog2(BOX_H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [XW-1:0] o_dx,
    output logic [YW-1:0] o_dy,
    output logic          o_last_col,
    output logic          o_last_row,
    output logic          o_last_pixel
);

    localparam logic [XW-1:0] X_LAST = XW'(BOX_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(BOX_H - 1);

    logic [XW-1:0] r_dx;
    logic [YW-1:0] r_dy;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_en) begin
            if (r_dx == X_LAST) begin
                r_dx <= '0;
                // Wrapping dy as well leaves the counter at the origin after the last pixel.
                r_dy <= (r_dy == Y_LAST) ? '0 : r_dy + YW'(1);
            end else begin
                r_dx <= r_dx + XW'(1);
            end
        end
    end

    assign o_dx         = r_dx;
    assign o_dy         = r_dy;
    assign o_last_col   = (r_dx == X_LAST);
    assign o_last_row   = (r_dy == Y_LAST);
    assign o_last_pixel = o_last_col && o_last_row;

endmodule

// File: rtl/box_plotter.sv
// rtl/box_plotter.sv - rasters one filled or outlined BOX_W x BOX_H tile into the VGA pixel-write port
module box_plotter
    import box_plotter_pkg::*;
#(
    parameter int BOX_W = BOX_W_DEF,
    parameter int BOX_H = BOX_H_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       draw_full,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int XW = $clog2(BOX_W);
    localparam int YW = $clog2(BOX_H);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_x0;
    logic [7:0]    r_y0;
    logic [2:0]    r_colour;
    logic          r_full;
    logic [XW-1:0] w_dx;
    logic [YW-1:0] w_dy;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_last_pixel;
    logic          w_border;

    box_plotter_raster_counter #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (r_state == IDLE),
        .i_en         (r_state == DRAW),
        .o_dx         (w_dx),
        .o_dy         (w_dy),
        .o_last_col   (w_last_col),
        .o_last_row   (w_last_row),
        .o_last_pixel (w_last_pixel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_colour <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Request fields are captured only on acceptance, so later input changes cannot disturb a tile.
            if (r_state == IDLE && go) begin
                r_x0     <= x_in;
                r_y0     <= y_in;
                r_colour <= colour_in;
                r_full   <= draw_full;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (go) w_next = DRAW;
            DRAW:    if (w_last_pixel) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_border   = (w_dx == '0) || w_last_col || (w_dy == '0) || w_last_row;
    assign vga_x      = r_x0 + 8'(w_dx);
    assign vga_y      = r_y0 + 8'(w_dy);
    assign vga_colour = (r_state == DRAW) ? r_colour : 3'b000;
    assign plot       = (r_state == DRAW) && (r_full || w_border);
    assign busy       = (r_state == DRAW) || (r_state == DONE);
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_box_plotter.sv
// tb/tb_box_plotter.sv - directed self-checking bench for box_plotter
module tb_box_plotter;
    import box_plotter_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [2:0] colour_in;
    logic       draw_full;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int plots;
    int dones;

    box_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .go         (go),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .draw_full  (draw_full),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_plot"}, 32'(plot), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_colour"}, 32'(vga_colour), 0);
    endtask

    // Issues one request and checks every pixel of the tile; at cycle disturb_at go and all inputs are perturbed.
    task automatic run_tile(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c,
                            input logic f, input int disturb_at, input int exp_plots);
        int dx;
        int dy;
        logic bord;
        x_in = x; y_in = y; colour_in = c; draw_full = f; go = 1'b1;
        tick();
        go = 1'b0;
        plots = 0;
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            dx = i % 10;
            dy = i / 10;
            bord = (dx == 0) || (dx == 9) || (dy == 0) || (dy == 6);
            check("pix_x", 32'(vga_x), 32'((x + 8'(dx)) & 8'hff));
            check("pix_y", 32'(vga_y), 32'((y + 8'(dy)) & 8'hff));
            check("pix_plot", 32'(plot), 32'(f || bord));
            check("pix_busy", 32'(busy), 1);
            if (plot) check("pix_colour", 32'(vga_colour), 32'(c));
            if (plot) plots++;
            if (done) dones++;
            if (i == disturb_at) begin
                go = 1'b1; x_in = ~x; y_in = ~y; colour_in = ~c; draw_full = ~f;
            end else begin
                go = 1'b0;
            end
            tick();
        end
        check("plot_count", plots, exp_plots);
        check("no_early_done", dones, 0);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("done_plot", 32'(plot), 0);
        tick();
        check_idle("after_done");
        tick();
        check_idle("no_second_tile");
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; x_in = '0; y_in = '0; colour_in = '0; draw_full = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset_x", 32'(vga_x), 0);
        check("reset_y", 32'(vga_y), 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("idle");
        end

        run_tile(8'd28, 8'd30, COLOUR_RED, 1'b1, -1, 70);
        run_tile(8'd28, 8'd30, COLOUR_WHITE, 1'b0, -1, 30);
        run_tile(8'd28, 8'd30, COLOUR_RED, 1'b1, 30, 70);
        go = 1'b0;

        x_in = 8'd28; y_in = 8'd30; colour_in = COLOUR_WHITE; draw_full = 1'b1; go = 1'b1;
        tick();
        go = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        reset = 1'b1;
        go = 1'b1;
        tick();
        reset = 1'b0;
        go = 1'b0;
        check_idle("mid_reset");
        check("mid_reset_x", 32'(vga_x), 0);
        check("mid_reset_y", 32'(vga_y), 0);
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        check("mid_reset_no_done", dones, 0);
        run_tile(8'd40, 8'd50, COLOUR_WHITE, 1'b1, -1, 70);

        run_tile(8'd250, 8'd252, COLOUR_RED, 1'b1, -1, 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
